uart_tx_arbiter: RTL

- Shares one UART_TX transmitter between N_REQ byte requesters.
- Sequences each frame: captures the byte, latches the bit-period configuration, drives a clean rising edge on the TX start input, then times the full frame (start + 8 data + parity + stop) plus a guard interval before the next grant.
- The TX exposes no busy/done signal, so all frame timing is reconstructed here from clks_per_bit.
- Sits between the host-side byte sources and the UART_TX instance.

---
 rtl/uart_ctrl_pkg.sv | 32 +++
 rtl/uart_tx_arbiter_if.sv | 32 +++
 rtl/uart_rr_arbiter.sv | 78 +++++++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl_pkg
// Description : Shared types and constants for the UART_TX arbiter.
//               Provides the sequencer state encoding and the frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

  localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop
  localparam int CNT_W      = 16;
  localparam int CPB_W      = 10;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_START = 2'd2,
    ST_FRAME = 2'd3
  } state_t;

  // Whole-frame duration in clocks, including the trailing guard interval.
  // 11*(1023+1)+guard still fits in 16 bits.
  function automatic logic [CNT_W-1:0] frame_clks(input logic [CPB_W-1:0] cpb,
                                                  input logic [CNT_W-1:0] guard);
    logic [CNT_W-1:0] w_bit_clks;
    w_bit_clks = {{(CNT_W-CPB_W){1'b0}}, cpb} + CNT_W'(1);
    return CNT_W'(FRAME_BITS) * w_bit_clks + guard;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester / UART_TX bundle for the arbiter.
//               master : byte sources (drive req, req_data, cfg_clks_per_bit)
//               slave  : arbiter (drives gnt, grant_id, busy, tx_* outputs)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [9:0]         cfg_clks_per_bit;
  logic [N_REQ-1:0]   gnt;
  logic [2:0]         grant_id;
  logic               busy;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic [9:0]         tx_clks_per_bit;

  modport master (
    output req, req_data, cfg_clks_per_bit,
    input  gnt, grant_id, busy, tx_data, tx_start, tx_clks_per_bit
  );

  modport slave (
    input  req, req_data, cfg_clks_per_bit,
    output gnt, grant_id, busy, tx_data, tx_start, tx_clks_per_bit
  );
endinterface
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_arbiter
// Description : Combinational winner select among N_REQ level requests.
//               Default: round-robin from a registered pointer, which moves to
//               winner+1 whenever a grant is taken.
//               UART_ARB_FIXED_PRIO_EN: lowest index wins, no pointer.
// Ports       : clk, rst_n   - clock, async active-low reset
//               i_req        - request vector
//               i_take       - grant is being taken this cycle
//               o_any        - at least one request is high
//               o_win        - winning index
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [N_REQ-1:0] i_req,
  input  wire logic             i_take,
  output logic                  o_any,
  output logic [IDX_W-1:0]      o_win
);

  logic [IDX_W-1:0] w_win;

  assign o_any = |i_req;
  assign o_win = w_win;

`ifdef UART_ARB_FIXED_PRIO_EN

  wire w_unused = clk ^ rst_n ^ i_take;

  always_comb begin
    w_win = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (i_req[i]) w_win = IDX_W'(i);
    end
  end

`else

  logic [IDX_W-1:0]   r_ptr;
  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;
  logic [IDX_W:0]     w_sum;

  // Rotate the request vector so the pointer position sits at bit 0; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  assign w_dbl = {i_req, i_req} >> r_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_off = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W+1)'(N_REQ)) w_sum = w_sum - (IDX_W+1)'(N_REQ);
    w_win = w_sum[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_take && o_any) begin
      r_ptr <= (w_win == IDX_W'(N_REQ-1)) ? '0 : w_win + IDX_W'(1);
    end
  end

`endif

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART_TX between N_REQ byte requesters. Captures the
//               winning byte and bit-period, pulses tx_start for START_HOLD
//               clocks, then times the whole frame plus a guard interval from
//               the latched clks_per_bit (the TX has no done/busy output).
//               Optional macro UART_ARB_FIXED_PRIO_EN selects fixed priority
//               (lowest index wins) instead of round-robin.
// Ports       : clk, rst_n   - clock, async active-low reset
//               bus (slave)  - req/req_data/cfg_clks_per_bit in;
//                              gnt/grant_id/busy/tx_data/tx_start/
//                              tx_clks_per_bit out (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int START_HOLD = 4,
  parameter int GUARD_CLKS = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  uart_tx_arbiter_if.slave  bus
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_REQ-1:0]   r_gnt;
  logic [IDX_W-1:0]   r_grant_id;
  logic               r_busy;
  logic [7:0]         r_tx_data;
  logic               r_tx_start;
  logic [CPB_W-1:0]   r_tx_cpb;

  logic               w_any;
  logic [IDX_W-1:0]   w_win;
  logic               w_take;
  logic [7:0]         w_byte;

  assign w_take = (r_state == ST_IDLE);

  uart_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (bus.req),
    .i_take (w_take),
    .o_any  (w_any),
    .o_win  (w_win)
  );

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == IDX_W'(i)) w_byte = bus.req_data[8*i +: 8];
    end
  end

  // The bit-period output and INIT timer track cfg while reset is held, so
  // the TX's own out-of-reset frame is timed with the setting it started on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_cnt      <= frame_clks(bus.cfg_clks_per_bit, CNT_W'(GUARD_CLKS));
      r_gnt      <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b1;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_tx_cpb   <= bus.cfg_clks_per_bit;
    end else begin
      r_gnt <= '0;
      case (r_state)
        ST_INIT: begin
          r_tx_cpb <= bus.cfg_clks_per_bit;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (w_any) begin
            r_tx_data  <= w_byte;
            r_tx_cpb   <= bus.cfg_clks_per_bit;
            r_gnt      <= N_REQ'(1) << w_win;
            r_grant_id <= w_win;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_cnt      <= CNT_W'(START_HOLD);
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt == CNT_W'(1)) begin
            r_tx_start <= 1'b0;
            r_cnt      <= frame_clks(r_tx_cpb, CNT_W'(GUARD_CLKS));
            r_state    <= ST_FRAME;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_FRAME: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state    <= ST_INIT;
          r_busy     <= 1'b1;
          r_tx_start <= 1'b0;
          r_cnt      <= frame_clks(r_tx_cpb, CNT_W'(GUARD_CLKS));
        end
      endcase
    end
  end

  assign bus.gnt             = r_gnt;
  assign bus.grant_id        = r_grant_id;
  assign bus.busy            = r_busy;
  assign bus.tx_data         = r_tx_data;
  assign bus.tx_start        = r_tx_start;
  assign bus.tx_clks_per_bit = r_tx_cpb;

endmodule
`default_nettype wire
